// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - button sync/debounce/repeat front end with round-robin event issue
module button_event_scheduler #(
   parameter int N_BUTTONS       = 4,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int HOLD_CYCLES     = 0,
   parameter int REPEAT_CYCLES   = 250
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_BUTTONS-1:0]         buttons,
   output logic                         event_valid,
   output logic [$clog2(N_BUTTONS)-1:0] event_id,
   input  logic                         event_ready,
   output logic [N_BUTTONS-1:0]         pending,
   output logic                         overrun
);

   localparam int IDW    = $clog2(N_BUTTONS);
   localparam int DCW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HCW    = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;

   localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [HCW-1:0] REP_LAST  = HCW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REPEAT,
      S_PRESSED
   } state_t;

   logic [N_BUTTONS-1:0] sync1;
   logic [N_BUTTONS-1:0] sync2;
   logic [N_BUTTONS-1:0] stable;
   logic [DCW-1:0]       db_cnt   [N_BUTTONS];

   state_t               state    [N_BUTTONS];
   state_t               state_n  [N_BUTTONS];
   logic [HCW-1:0]       hr_cnt   [N_BUTTONS];
   logic [HCW-1:0]       hr_cnt_n [N_BUTTONS];
   logic [N_BUTTONS-1:0] set_req;

   logic [IDW-1:0]       last_grant;
   logic [IDW-1:0]       grant_id;
   logic [IDW-1:0]       hi_id;
   logic [IDW-1:0]       lo_id;
   logic                 hi_found;
   logic                 lo_found;
   logic                 load;
   logic [N_BUTTONS-1:0] grant_mask;

   // Two-flop synchronizer followed by a per-button debounce counter on the synced level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         for (int i = 0; i < N_BUTTONS; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= buttons;
         sync2 <= sync1;
         for (int i = 0; i < N_BUTTONS; i++) begin
            if (sync2[i] != stable[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  stable[i] <= ~stable[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Press/hold/repeat state and its shared hold-repeat counter per button.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_BUTTONS; i++) begin
            state[i]  <= S_IDLE;
            hr_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BUTTONS; i++) begin
            state[i]  <= state_n[i];
            hr_cnt[i] <= hr_cnt_n[i];
         end
      end
   end

   // Next state and press requests; a release always returns to idle without an event.
   always_comb begin
      for (int i = 0; i < N_BUTTONS; i++) begin
         state_n[i]  = state[i];
         hr_cnt_n[i] = hr_cnt[i];
         set_req[i]  = 1'b0;
         if (!stable[i]) begin
            state_n[i] = S_IDLE;
         end else begin
            case (state[i])
               S_IDLE: begin
                  set_req[i]  = 1'b1;
                  hr_cnt_n[i] = '0;
                  state_n[i]  = (HOLD_CYCLES > 0) ? S_HOLD : S_PRESSED;
               end
               S_HOLD: begin
                  if (hr_cnt[i] == HOLD_LAST) begin
                     set_req[i]  = 1'b1;
                     hr_cnt_n[i] = '0;
                     state_n[i]  = S_REPEAT;
                  end else begin
                     hr_cnt_n[i] = hr_cnt[i] + 1'b1;
                  end
               end
               S_REPEAT: begin
                  if (hr_cnt[i] == REP_LAST) begin
                     set_req[i]  = 1'b1;
                     hr_cnt_n[i] = '0;
                  end else begin
                     hr_cnt_n[i] = hr_cnt[i] + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Round-robin pick: lowest pending index above last_grant, else lowest pending overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int j = N_BUTTONS - 1; j >= 0; j--) begin
         if (pending[j]) begin
            lo_found = 1'b1;
            lo_id    = IDW'(j);
            if (j > int'(last_grant)) begin
               hi_found = 1'b1;
               hi_id    = IDW'(j);
            end
         end
      end
      grant_id   = hi_found ? hi_id : lo_id;
      load       = (!event_valid || event_ready) && lo_found;
      grant_mask = '0;
      if (load) grant_mask[grant_id] = 1'b1;
   end

   // Pending flags (a new set beats a same-cycle grant), overrun pulse and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending     <= '0;
         overrun     <= 1'b0;
         event_valid <= 1'b0;
         event_id    <= '0;
         last_grant  <= IDW'(N_BUTTONS - 1);
      end else begin
         pending <= (pending & ~grant_mask) | set_req;
         overrun <= |(set_req & pending & ~grant_mask);
         if (load) begin
            event_valid <= 1'b1;
            event_id    <= grant_id;
            last_grant  <= grant_id;
         end else if (!event_valid || event_ready) begin
            event_valid <= 1'b0;
         end
      end
   end

endmodule
